fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard controller for the pipelined MIPS core.
- Tracks in-flight destination registers in an internal tag pipeline of configurable depth.
- Sits between ID and EX. Produces registered per-operand ALU-input mux selects that are valid while the consumer is in EX.
- Produces a combinational stall for load-use hazards of configurable latency.
- Guarantees youngest-producer priority and a defined no-match default.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction (0=rs, 1=rt).
- FWD_DEPTH, 2, number of post-EX stages that can forward (2 = EX/MEM, MEM/WB).
- LOAD_LAT, 1, stages after EX in which a load result is not yet forwardable (0..FWD_DEPTH-1).
- SEL_W, clog2(FWD_DEPTH+1), select width; derived, not overridable.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- issue_valid  in  1  ID holds a valid instruction.
- issue_rd  in  REG_ADDR_W  destination of the ID instruction.
- issue_reg_write  in  1  ID instruction writes issue_rd.
- issue_mem_read  in  1  ID instruction is a load.
- src_addr  in  NUM_SRC*REG_ADDR_W  ID source addresses; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_used  in  NUM_SRC  operand i is actually read.
- flush  in  1  squash the ID instruction this cycle (branch/jump redirect).
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- fwd_sel  out  NUM_SRC*SEL_W  per-operand EX mux select: 0 = register file, k = stage k after EX (1 = EX/MEM).

Behaviour:
- Tag pipeline: entries T[0..FWD_DEPTH-1], each holding {v, rd, wr, ld}.
  - T[0] is the instruction currently in EX; T[k] is k stages later.
- Every posedge, unconditionally:
  - T[k] <= T[k-1] for k >= 1.
  - T[0] <= {issue_valid & !stall & !flush, issue_rd, issue_reg_write, issue_mem_read}.
  - A stalled or flushed cycle inserts a bubble (v=0).
- Match of operand i against entry k:
  - requires T[k].v & T[k].wr & src_used[i] & (T[k].rd == src addr i) & (src addr i != 0).
  - Register 0 never matches.
- Forward select, computed in ID for the consumer that will enter EX next cycle:
  - Entry T[k] will sit at stage k+1 when the consumer is in EX.
  - sel_next[i] = k+1 for the smallest matching k in 0..FWD_DEPTH-1 (youngest wins); 0 if no match.
  - A match on T[FWD_DEPTH-1] yields FWD_DEPTH.
- fwd_sel registered, 1-cycle latency: fwd_sel <= (stall | flush | !issue_valid) ? 0 : sel_next.
- Load-use stall (combinational):
  - stall = !flush & issue_valid & OR over i,k of (match(i,k) & T[k].ld & k < LOAD_LAT).
  - Only the youngest matching producer is evaluated; an older matching load is shadowed by a younger non-load.
  - Stall persists until the load advances past LOAD_LAT. With LOAD_LAT=1 that is exactly 1 cycle; with LOAD_LAT=L it is up to L cycles.
  - After a stall, the re-presented consumer receives sel = LOAD_LAT+1 for that operand.
- Flush has priority over stall: flush=1 forces stall=0, a T[0] bubble, and fwd_sel=0.
- Reset (async, active-high):
  - All T[k].v=0, fwd_sel=0. stall evaluates to 0 because no entries are valid.
  - Reset asserted mid-stall clears the stall immediately (combinationally via the cleared entries).
  - First issue after reset release proceeds normally.
- issue_valid=0 in ID: no stall; bubble into T[0].
- All operands are evaluated independently. Both operands may select the same stage simultaneously.

Test Plan:
- Default params. ADD r5 issued, then SUB using rs=r5, rt=r6 → cycle after SUB issues: fwd_sel rs=1, rt=0; stall=0 throughout.
- ADD r5; NOP; OR rs=r5 → OR in EX sees rs sel=2. ADD r5; ADD r5; AND rs=r5 → sel=1 (youngest wins, not 2).
- LW r7; ADD rs=r7, rt=r7 → stall=1 for exactly 1 cycle, bubble in EX (fwd_sel=0); ADD re-presented, next cycle both sel=2.
- Register 0: ADD r0 then SUB rs=r0 → sel=0, no stall. LW r0; use r0 → no stall.
- LW r9 with ADD rs=r9 in ID and flush=1 → stall=0, T[0] bubble, fwd_sel=0. Assert reset during a LW-use stall → stall drops to 0 asynchronously; fwd_sel=0.
- FWD_DEPTH=3, LOAD_LAT=2, NUM_SRC=3: LW r3; use r3 → stall 2 cycles, then sel=3 (SEL_W=2). Operand 2 with src_used=0 and matching address → never stalls, sel=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller; tracks in-flight producers in a tag pipe.
// fwd_sel is registered (valid while the consumer is in EX); stall is combinational and bubbles EX.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_reg_write,
  input  logic                          issue_mem_read,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel
);

  logic [FWD_DEPTH-1:0]                 v_q, v_d;
  logic [FWD_DEPTH-1:0]                 wr_q, wr_d;
  logic [FWD_DEPTH-1:0]                 ld_q, ld_d;
  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [NUM_SRC*SEL_W-1:0]             fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0]             sel_next;
  logic [NUM_SRC-1:0]                   ld_hit;
  logic [REG_ADDR_W-1:0]                src_i;

  // Scan oldest to youngest so the youngest matching producer overwrites the result.
  always_comb begin
    sel_next = '0;
    ld_hit   = '0;
    src_i    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_i = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && wr_q[k] && src_used[i] && (src_i != '0) && (rd_q[k] == src_i)) begin
          sel_next[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          ld_hit[i]                  = ld_q[k] && (k < LOAD_LAT);
        end
      end
    end
  end

  assign stall = !flush && issue_valid && (|ld_hit);

  always_comb begin
    v_d  = '0;
    wr_d = '0;
    ld_d = '0;
    rd_d = '0;
    v_d[0]  = issue_valid && !stall && !flush;
    rd_d[0] = issue_rd;
    wr_d[0] = issue_reg_write;
    ld_d[0] = issue_mem_read;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      rd_d[k] = rd_q[k-1];
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
    end
    fwd_sel_d = (stall || flush || !issue_valid) ? '0 : sel_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q       <= '0;
      wr_q      <= '0;
      ld_q      <= '0;
      rd_q      <= '0;
      fwd_sel_q <= '0;
    end else begin
      v_q       <= v_d;
      wr_q      <= wr_d;
      ld_q      <= ld_d;
      rd_q      <= rd_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign fwd_sel = fwd_sel_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default-parameter vector table plus hand sequences
// for mid-stall reset and a FWD_DEPTH=3 / LOAD_LAT=2 / NUM_SRC=3 instance.
module tb_fwd_hazard_unit;

  logic clk;
  logic reset;

  // Default-parameter instance
  logic        vld, wr, ld, flush;
  logic [4:0]  rd;
  logic [9:0]  src;
  logic [1:0]  used;
  logic        stall1;
  logic [3:0]  sel1;

  // Deep instance
  logic        vld2, wr2, ld2, flush2;
  logic [4:0]  rd2;
  logic [14:0] src2;
  logic [2:0]  used2;
  logic        stall2;
  logic [5:0]  sel2;

  int n_cmp;
  int n_err;

  fwd_hazard_unit dut1 (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (vld),
    .issue_rd        (rd),
    .issue_reg_write (wr),
    .issue_mem_read  (ld),
    .src_addr        (src),
    .src_used        (used),
    .flush           (flush),
    .stall           (stall1),
    .fwd_sel         (sel1)
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .FWD_DEPTH(3), .LOAD_LAT(2)) dut2 (
    .clk             (clk),
    .reset           (reset),
    .issue_valid     (vld2),
    .issue_rd        (rd2),
    .issue_reg_write (wr2),
    .issue_mem_read  (ld2),
    .src_addr        (src2),
    .src_used        (used2),
    .flush           (flush2),
    .stall           (stall2),
    .fwd_sel         (sel2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic       flush;
    logic       exp_stall;
    logic [3:0] exp_sel;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one ID cycle into dut1: stall checked mid-cycle, fwd_sel checked after the edge.
  task automatic step1(input vec_t t, input string nm);
    @(negedge clk);
    vld   = t.vld;
    rd    = t.rd;
    wr    = t.wr;
    ld    = t.ld;
    src   = {t.s1, t.s0};
    used  = t.used;
    flush = t.flush;
    #1;
    check({nm, " stall"}, 32'(stall1), 32'(t.exp_stall));
    @(posedge clk);
    #1;
    check({nm, " fwd_sel"}, 32'(sel1), 32'(t.exp_sel));
  endtask

  task automatic step2(input logic v, input logic [4:0] rd_i, input logic wr_i, input logic ld_i,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] u, input logic exp_stall, input logic [5:0] exp_sel,
                       input string nm);
    @(negedge clk);
    vld2   = v;
    rd2    = rd_i;
    wr2    = wr_i;
    ld2    = ld_i;
    src2   = {s2, s1, s0};
    used2  = u;
    flush2 = 1'b0;
    #1;
    check({nm, " stall"}, 32'(stall2), 32'(exp_stall));
    @(posedge clk);
    #1;
    check({nm, " fwd_sel"}, 32'(sel2), 32'(exp_sel));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    n_cmp = 0;
    n_err = 0;
    //          vld   rd     wr    ld    s0     s1     used   flush stall sel
    tbl[0]  = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd1,  5'd2,  2'b11, 1'b0, 1'b0, 4'b0000}; // ADD r5
    tbl[1]  = '{1'b1, 5'd8,  1'b1, 1'b0, 5'd5,  5'd6,  2'b11, 1'b0, 1'b0, 4'b0001}; // SUB r5,r6
    tbl[2]  = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 4'b0000}; // NOP
    tbl[3]  = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd1,  5'd2,  2'b11, 1'b0, 1'b0, 4'b0000}; // ADD r5
    tbl[4]  = '{1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 4'b0000}; // NOP
    tbl[5]  = '{1'b1, 5'd10, 1'b1, 1'b0, 5'd5,  5'd0,  2'b11, 1'b0, 1'b0, 4'b0010}; // OR r5 -> MEM/WB
    tbl[6]  = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd1,  5'd1,  2'b11, 1'b0, 1'b0, 4'b0000}; // ADD r5
    tbl[7]  = '{1'b1, 5'd5,  1'b1, 1'b0, 5'd2,  5'd3,  2'b11, 1'b0, 1'b0, 4'b0000}; // ADD r5
    tbl[8]  = '{1'b1, 5'd11, 1'b1, 1'b0, 5'd5,  5'd10, 2'b11, 1'b0, 1'b0, 4'b0001}; // AND: youngest
    tbl[9]  = '{1'b1, 5'd7,  1'b1, 1'b1, 5'd11, 5'd0,  2'b01, 1'b0, 1'b0, 4'b0001}; // LW r7
    tbl[10] = '{1'b1, 5'd12, 1'b1, 1'b0, 5'd7,  5'd7,  2'b11, 1'b0, 1'b1, 4'b0000}; // load-use
    tbl[11] = '{1'b1, 5'd12, 1'b1, 1'b0, 5'd7,  5'd7,  2'b11, 1'b0, 1'b0, 4'b1010}; // re-presented
    tbl[12] = '{1'b1, 5'd0,  1'b1, 1'b0, 5'd12, 5'd0,  2'b11, 1'b0, 1'b0, 4'b0001}; // ADD r0
    tbl[13] = '{1'b1, 5'd13, 1'b1, 1'b0, 5'd0,  5'd12, 2'b11, 1'b0, 1'b0, 4'b1000}; // SUB r0,r12
    tbl[14] = '{1'b1, 5'd0,  1'b1, 1'b1, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 4'b0000}; // LW r0
    tbl[15] = '{1'b1, 5'd14, 1'b1, 1'b0, 5'd0,  5'd0,  2'b11, 1'b0, 1'b0, 4'b0000}; // use r0
    tbl[16] = '{1'b1, 5'd9,  1'b1, 1'b1, 5'd0,  5'd0,  2'b00, 1'b0, 1'b0, 4'b0000}; // LW r9
    tbl[17] = '{1'b1, 5'd15, 1'b1, 1'b0, 5'd9,  5'd9,  2'b11, 1'b1, 1'b0, 4'b0000}; // flushed use
    tbl[18] = '{1'b0, 5'd0,  1'b0, 1'b0, 5'd9,  5'd9,  2'b11, 1'b0, 1'b0, 4'b0000}; // ID empty

    reset = 1'b1;
    vld = 1'b0; rd = '0; wr = 1'b0; ld = 1'b0; src = '0; used = '0; flush = 1'b0;
    vld2 = 1'b0; rd2 = '0; wr2 = 1'b0; ld2 = 1'b0; src2 = '0; used2 = '0; flush2 = 1'b0;
    #2;
    check("reset stall1", 32'(stall1), 32'd0);
    check("reset fwd_sel1", 32'(sel1), 32'd0);
    check("reset stall2", 32'(stall2), 32'd0);
    check("reset fwd_sel2", 32'(sel2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < NV; r++) step1(tbl[r], $sformatf("row%0d", r));

    // Reset asserted in the middle of a load-use stall
    t = '{1'b1, 5'd20, 1'b1, 1'b0, 5'd0,  5'd0, 2'b00, 1'b0, 1'b0, 4'b0000};
    step1(t, "pre ADD r20");
    t = '{1'b1, 5'd9,  1'b1, 1'b1, 5'd20, 5'd0, 2'b01, 1'b0, 1'b0, 4'b0001};
    step1(t, "pre LW r9");
    @(negedge clk);
    vld = 1'b1; rd = 5'd21; wr = 1'b1; ld = 1'b0; src = {5'd9, 5'd9}; used = 2'b11; flush = 1'b0;
    #1;
    check("midstall stall", 32'(stall1), 32'd1);
    check("midstall fwd_sel", 32'(sel1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset stall", 32'(stall1), 32'd0);
    check("async reset fwd_sel", 32'(sel1), 32'd0);
    @(negedge clk);
    vld = 1'b0;
    reset = 1'b0;
    t = '{1'b1, 5'd21, 1'b1, 1'b0, 5'd9,  5'd9, 2'b11, 1'b0, 1'b0, 4'b0000};
    step1(t, "post-reset ADD");
    t = '{1'b1, 5'd22, 1'b1, 1'b0, 5'd21, 5'd0, 2'b11, 1'b0, 1'b0, 4'b0001};
    step1(t, "post-reset SUB");
    @(negedge clk);
    vld = 1'b0;

    // FWD_DEPTH=3, LOAD_LAT=2, NUM_SRC=3
    step2(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 6'b000000, "d2 LW r3");
    step2(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd1, 5'd3, 3'b011, 1'b1, 6'b000000, "d2 use1");
    step2(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd1, 5'd3, 3'b011, 1'b1, 6'b000000, "d2 use2");
    step2(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd1, 5'd3, 3'b011, 1'b0, 6'b000011, "d2 use3");
    step2(1'b1, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 6'b000000, "d2 LW r6");
    step2(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 6'b000000, "d2 ADD r6");
    step2(1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 5'd0, 5'd0, 3'b001, 1'b0, 6'b000001, "d2 shadow");
    step2(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 3'b100, 1'b0, 6'b100000, "d2 op2");
    step2(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 6'b000000, "d2 LW r3b");
    step2(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 3'b000, 1'b0, 6'b000000, "d2 unused op2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
